// File: rtl/aftab_bus_arbiter4_pkg.sv
// Shared AFTAB definitions for the 4-way bus arbiter: FSM state encoding,
// requester index constants and the round-robin winner search.
package aftab_bus_arbiter4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA  = 2'd1;
    localparam logic [1:0] REQ_CSR   = 2'd2;
    localparam logic [1:0] REQ_DEBUG = 2'd3;

    // The pointer resets to the last index, so the search starts at REQ_FETCH.
    localparam logic [1:0] PTR_RESET = REQ_DEBUG;

    // First set request bit found when scanning from ptr+1 upward, modulo 4.
    // The result is don't-care when req is all zeros.
    function automatic logic [1:0] rr_winner(input logic [3:0] req,
                                             input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_winner = ptr;
        found     = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                rr_winner = idx;
                found     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/aftab_bus_arbiter4_if.sv
// Request/grant bundle between the requesters, the shared memory port and
// the arbiter. The arbiter is the slave side of this bundle.
interface aftab_bus_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gntIdx;
    logic       gntValid;
    logic       timeoutErr;

    modport master (
        output req, done,
        input  gnt, gntIdx, gntValid, timeoutErr
    );

    modport slave (
        input  req, done,
        output gnt, gntIdx, gntValid, timeoutErr
    );
endinterface

// File: rtl/aftab_bus_arbiter4_dec.sv
// 2-to-4 one-hot decoder with enable; all zeros when disabled.
module aftab_decoder2to4 (
    input  logic [1:0] dataIn,
    input  logic       En,
    output logic [3:0] dataOut
);

    // Decode the index into a one-hot word when enabled.
    always_comb begin
        // NOTE: default first so every path assigns dataOut and no latch is inferred.
        dataOut = 4'b0000;
        if (En) begin
            dataOut[dataIn] = 1'b1;
        end
    end

endmodule

// File: rtl/aftab_bus_arbiter4.sv
// Four-requester round-robin bus arbiter with completion, abort and
// timeout release. One idle turnaround cycle follows every release.
module aftab_bus_arbiter4
    import aftab_bus_arbiter4_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    aftab_bus_arbiter4_if.slave  bus
);

    // Wide enough to hold TIMEOUT; the count tops out at TIMEOUT-1 before release.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    logic [1:0]        r_ptr;
    logic [1:0]        r_gntIdx;
    logic              r_gntValid;
    logic              r_timeoutErr;
    logic [CNT_W-1:0]  r_cnt;

    arb_state_t        w_state_nxt;
    logic [1:0]        w_ptr_nxt;
    logic [1:0]        w_gntIdx_nxt;
    logic              w_gntValid_nxt;
    logic              w_timeoutErr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [1:0]        w_winner;
    logic              w_done;
    logic              w_abort;
    logic              w_timeout;

    assign w_winner  = rr_winner(bus.req, r_ptr);
    assign w_done    = bus.done;
    assign w_abort   = !bus.req[r_gntIdx];
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_state      <= IDLE;
            r_ptr        <= PTR_RESET;
            r_gntIdx     <= 2'd0;
            r_gntValid   <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_gntIdx     <= w_gntIdx_nxt;
            r_gntValid   <= w_gntValid_nxt;
            r_timeoutErr <= w_timeoutErr_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, watch release events in GRANT.
    // Release priority is done, then abort, then timeout; only a pure
    // timeout raises the error pulse.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_gntIdx_nxt     = r_gntIdx;
        w_gntValid_nxt   = r_gntValid;
        w_timeoutErr_nxt = 1'b0;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_state_nxt    = GRANT;
                    w_gntIdx_nxt   = w_winner;
                    w_gntValid_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                end
            end
            GRANT: begin
                if (w_done || w_abort || w_timeout) begin
                    w_state_nxt      = IDLE;
                    w_gntValid_nxt   = 1'b0;
                    w_ptr_nxt        = r_gntIdx;
                    w_cnt_nxt        = '0;
                    w_timeoutErr_nxt = !w_done && !w_abort;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_gntValid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.gntIdx     = r_gntIdx;
    assign bus.gntValid   = r_gntValid;
    assign bus.timeoutErr = r_timeoutErr;

    aftab_decoder2to4 u_gnt_dec (
        .dataIn  (r_gntIdx),
        .En      (r_gntValid),
        .dataOut (bus.gnt)
    );

endmodule

// File: doc/aftab_bus_arbiter4.md
AFTAB_BUS_ARBITER4 -- requirements
Module: aftab_bus_arbiter4

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of grant cycles allowed before a forced release; legal range is 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low.
REQ-004 req  input  4  per-requester access request; bit i = requester i (0 fetch, 1 data, 2 CSR/interrupt, 3 debug).
REQ-005 done  input  1  completion strobe from the shared memory port for the current owner.
REQ-006 gnt  output  4  one-hot grant; all zeros when no owner.
REQ-007 gntIdx  output  2  binary index of the current owner; holds the last owner when gntValid=0.
REQ-008 gntValid  output  1  high while any grant is active.
REQ-009 timeoutErr  output  1  one-cycle pulse when an owner is forcibly released by timeout.

Function
REQ-010 The block SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-011 IDLE: if req!=0 at an edge, the block SHALL select the winner round-robin, searching from ptr+1 upward modulo 4, and enter GRANT.
REQ-012 Latency: req sampled in IDLE at edge N SHALL produce gnt/gntIdx/gntValid at edge N (visible in cycle N+1); all outputs are registered.
REQ-013 GRANT: gnt SHALL remain stable, ignoring changes on other req bits, until one of three release events occurs:
- done=1 (completion)
- req[gntIdx]=0 (abort)
- timeout
REQ-014 On release at edge M, the block SHALL clear gnt and gntValid, set ptr<=gntIdx, and return to IDLE.
REQ-015 The earliest new grant after a release SHALL be at edge M+1, giving one mandatory idle turnaround cycle.
REQ-016 Timeout counter: cleared on entry to GRANT; incremented every GRANT cycle without a release event.
REQ-017 If TIMEOUT grant cycles pass with no done and no abort, the block SHALL force a release at the edge after the last grant cycle and pulse timeoutErr=1 for exactly the following cycle.
REQ-018 If done and the timeout condition coincide in the same cycle, the event SHALL be a completion: no timeoutErr.
REQ-019 If done and abort coincide in the same cycle, the event SHALL be a completion; the observable effect is identical to REQ-014.
REQ-020 done in IDLE SHALL be ignored.
REQ-021 The counter width SHALL be ceil(log2(TIMEOUT+1)); it SHALL never wrap within a grant.
REQ-022 The ptr increment SHALL wrap modulo 4 (3+1 -> 0).
REQ-023 Invariants: gnt SHALL never have more than one bit set; gnt SHALL equal decode(gntIdx) when gntValid=1, else 0.
REQ-024 A requester SHALL be re-granted back-to-back only when no other req bit is set at the arbitration edge.

Reset
REQ-025 With rst=0 at an edge, the block SHALL set:
- state to IDLE
- gnt=0000, gntValid=0, gntIdx=0, timeoutErr=0
- counter=0
- ptr=3, so requester 0 has first priority
REQ-026 Reset SHALL take effect mid-grant or mid-timeout with no completion or error pulse; arbitration SHALL resume at the first edge with rst=1.

Structure
REQ-027 State encodings (IDLE=0, GRANT=1) and requester index constants SHALL reside in the shared AFTAB definitions package/header.
REQ-028 The one-hot gnt SHALL be produced by one instance of aftab_decoder2to4 (dataIn=gntIdx register, En=gntValid register); no other sub-modules are required.
REQ-029 The round-robin winner search SHALL be purely combinational from req and ptr; the state, ptr, counter, gntIdx, gntValid and timeoutErr SHALL be registers.

Verification
REQ-030 Reset, then req=0001 at edge 1 -> gnt=0001, gntIdx=0, gntValid=1 in the following cycle; done pulse -> gnt=0000 one cycle, ptr=0.
REQ-031 req=1111 held, done pulsed once per grant -> grant order 0,1,2,3,0, each separated by exactly one idle cycle.
REQ-032 TIMEOUT=16, req=0100 held, done never asserted -> gnt=0100 for 16 cycles, then gnt=0000 with timeoutErr=1 for exactly 1 cycle; next grant goes to 2 again only if it is the sole requester.
REQ-033 done asserted in the 16th grant cycle -> normal release, timeoutErr stays 0.
REQ-034 Owner 1 drops req[1] mid-grant while req=1011 -> release next edge, next grant goes to 3.
REQ-035 rst=0 during GRANT of requester 2 -> all outputs 0 next cycle; after rst=1 with req=1111 -> grant goes to requester 0.
